// File: rtl/sync_gen_pkg.sv
// sync_gen_pkg: shared modes, FSM states, default config and PRBS7 helpers for sync_gen.
package sync_gen_pkg;
  typedef enum logic [1:0] {
    SG_MODE_SQUARE = 2'd0,
    SG_MODE_WALK   = 2'd1,
    SG_MODE_PRBS   = 2'd2,
    SG_MODE_OFF    = 2'd3
  } sg_mode_e;
  typedef enum logic [1:0] {SG_IDLE, SG_RUN, SG_STOP} sg_state_e;
  localparam int SG_DEF_DIV   = 499;
  localparam int SG_DEF_FRAME = 511;
  localparam int SG_DEF_SYNC  = 9;
  // x^7 + x^6 + 1
  localparam logic [6:0] SG_PRBS_TAPS = 7'b1100000;
  function automatic logic [6:0] sg_seed(input logic [6:0] seed, input int k);
    logic [6:0] r;
    r = seed;
    for (int i = 0; i < k % 7; i++) r = {r[5:0], r[6]};
    return r == '0 ? 7'h01 : r;
  endfunction
endpackage

// File: rtl/sync_gen_lfsr.sv
// sync_gen_lfsr: 7-bit PRBS generator with seed reload and per-sample advance.
module sync_gen_lfsr import sync_gen_pkg::*; #(
  parameter logic [6:0] SEED = 7'h01
) (
  input  logic mclk,
  input  logic reset_n,
  input  logic load,
  input  logic adv,
  output logic q
);
  logic [6:0] s;
  always_ff @(posedge mclk or negedge reset_n)
    if (!reset_n) s <= SEED;
    else if (load) s <= SEED;
    else if (adv) s <= {s[5:0], ^(s & SG_PRBS_TAPS)};
  assign q = s[0];
endmodule

// File: rtl/sync_gen.sv
// sync_gen: configurable sample clock, frame sync and test-pattern generator on mclk.
module sync_gen import sync_gen_pkg::*; #(
  parameter int         DIV_NBIT   = 16,
  parameter int         FRAME_NBIT = 10,
  parameter int         NCHN       = 4,
  parameter logic [6:0] LFSR_SEED  = 7'h5A
) (
  input  logic                  mclk,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic                  cfg_load,
  input  logic [DIV_NBIT-1:0]   cfg_div,
  input  logic [FRAME_NBIT-1:0] cfg_frame,
  input  logic [FRAME_NBIT-1:0] cfg_sync,
  input  logic [1:0]            cfg_mode,
  output logic                  spclk,
  output logic                  sync,
  output logic [NCHN-1:0]       data,
  output logic                  sample_tick,
  output logic                  frame_start,
  output logic [FRAME_NBIT-1:0] sample_idx,
  output logic                  busy
);
  sg_state_e             state;
  sg_mode_e              act_mode, pnd_mode;
  logic [DIV_NBIT-1:0]   div, act_div, pnd_div;
  logic [FRAME_NBIT-1:0] idx, act_frame, act_sync, pnd_frame, pnd_sync;
  logic                  pend, idle, last, bnd, copy;
  logic [DIV_NBIT:0]     half_div;
  logic [FRAME_NBIT:0]   half_frame;
  logic [NCHN-1:0]       prbs, pat;
  assign idle       = state == SG_IDLE;
  assign last       = div == act_div;
  assign bnd        = !idle && last && idx == act_frame;
  assign copy       = pend && (idle || bnd);
  assign half_div   = ({1'b0, act_div} + 1'b1) >> 1;
  assign half_frame = ({1'b0, act_frame} + 1'b1) >> 1;
  assign busy       = !idle;
  for (genvar c = 0; c < NCHN; c++) begin : g_lfsr
    sync_gen_lfsr #(.SEED(sg_seed(LFSR_SEED, c))) u_lfsr (
      .mclk    (mclk),
      .reset_n (reset_n),
      .load    (idle || bnd),
      .adv     (!idle && last),
      .q       (prbs[c])
    );
  end
  always_comb begin
    pat = '0;
    for (int k = 0; k < NCHN; k++)
      pat[k] = act_mode == SG_MODE_SQUARE ? {1'b0, idx} < half_frame :
               act_mode == SG_MODE_WALK   ? 32'(idx) % NCHN == k :
               act_mode == SG_MODE_PRBS   ? prbs[k] : 1'b0;
  end
  always_ff @(posedge mclk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= SG_IDLE;
      div         <= '0;
      idx         <= '0;
      act_div     <= DIV_NBIT'(SG_DEF_DIV);
      act_frame   <= FRAME_NBIT'(SG_DEF_FRAME);
      act_sync    <= FRAME_NBIT'(SG_DEF_SYNC);
      act_mode    <= SG_MODE_SQUARE;
      pnd_div     <= DIV_NBIT'(SG_DEF_DIV);
      pnd_frame   <= FRAME_NBIT'(SG_DEF_FRAME);
      pnd_sync    <= FRAME_NBIT'(SG_DEF_SYNC);
      pnd_mode    <= SG_MODE_SQUARE;
      pend        <= 1'b0;
      spclk       <= 1'b0;
      sync        <= 1'b0;
      data        <= '0;
      sample_tick <= 1'b0;
      frame_start <= 1'b0;
      sample_idx  <= '0;
    end else begin
      state <= idle ? (en ? SG_RUN : SG_IDLE) : (!en && bnd) ? SG_IDLE : en ? SG_RUN : SG_STOP;
      div   <= idle || last ? '0 : div + 1'b1;
      idx   <= idle || bnd ? '0 : last ? idx + 1'b1 : idx;
      if (copy) begin
        act_div   <= pnd_div == '0 ? DIV_NBIT'(1) : pnd_div;
        act_frame <= pnd_frame == '0 ? FRAME_NBIT'(1) : pnd_frame;
        act_sync  <= pnd_sync;
        act_mode  <= pnd_mode;
      end
      // a load landing on the copy cycle stays pending for the next boundary
      if (cfg_load) begin
        pnd_div   <= cfg_div;
        pnd_frame <= cfg_frame;
        pnd_sync  <= cfg_sync;
        pnd_mode  <= sg_mode_e'(cfg_mode);
      end
      pend        <= cfg_load || (pend && !copy);
      spclk       <= !idle && {1'b0, div} < half_div;
      sync        <= !idle && idx < act_sync;
      data        <= idle ? '0 : pat;
      sample_tick <= !idle && last;
      frame_start <= !idle && div == '0 && idx == '0;
      sample_idx  <= idx;
    end
  end
endmodule

// File: tb/tb_sync_gen.sv
// tb_sync_gen: randomized scoreboard bench for sync_gen against a position-based frame model.
module tb_sync_gen;
  localparam int DN = 16;
  localparam int FN = 10;
  localparam int NC = 4;
  localparam int OW = FN + NC + 5;
  logic          mclk = 1'b0, reset_n = 1'b0, en = 1'b0, cfg_load = 1'b0;
  logic [DN-1:0] cfg_div = '0;
  logic [FN-1:0] cfg_frame = '0, cfg_sync = '0;
  logic [1:0]    cfg_mode = '0;
  logic          spclk, sync, sample_tick, frame_start, busy;
  logic [NC-1:0] data;
  logic [FN-1:0] sample_idx;
  int n_chk = 0, n_fail = 0;
  logic [OW-1:0] exp_q[$];
  int mst = 0, p = 0, cd = 499, cf = 511, cs = 9, cm = 0;
  int pd = 499, pf = 511, ps = 9, pm = 0;
  bit pflag = 0;

  sync_gen #(.DIV_NBIT(DN), .FRAME_NBIT(FN), .NCHN(NC), .LFSR_SEED(7'h5A)) dut (
    .mclk(mclk), .reset_n(reset_n), .en(en), .cfg_load(cfg_load),
    .cfg_div(cfg_div), .cfg_frame(cfg_frame), .cfg_sync(cfg_sync), .cfg_mode(cfg_mode),
    .spclk(spclk), .sync(sync), .data(data), .sample_tick(sample_tick),
    .frame_start(frame_start), .sample_idx(sample_idx), .busy(busy)
  );

  always #5 mclk = ~mclk;

  function automatic logic [OW-1:0] outs();
    return {busy, spclk, sync, data, sample_tick, frame_start, sample_idx};
  endfunction

  // PRBS7 as a bit recurrence: b[j+7] = b[j] ^ b[j+1], seed bits first (MSB first)
  function automatic logic prbs_bit(int k, int n);
    int v, r;
    int b[$];
    r = k % 7;
    v = ((32'h5A << r) | (32'h5A >> (7 - r))) & 127;
    if (v == 0) v = 1;
    for (int j = 0; j < 7; j++) b.push_back((v >> (6 - j)) & 1);
    for (int j = 0; j < n; j++) b.push_back(b[j] ^ b[j + 1]);
    return b[6 + n] != 0;
  endfunction

  task automatic model_step();
    int L, dv, s, nst;
    bit bnd, sp, sy, tk, fs;
    logic [NC-1:0] dat;
    if (!reset_n) begin
      mst = 0; p = 0; cd = 499; cf = 511; cs = 9; cm = 0;
      pd = 499; pf = 511; ps = 9; pm = 0; pflag = 0;
      exp_q.delete();
      return;
    end
    L = cd + 1; dv = p % L; s = p / L;
    bnd = mst != 0 && p == L * (cf + 1) - 1;
    sp = 0; sy = 0; tk = 0; fs = 0; dat = '0;
    if (mst != 0) begin
      sp = dv < L / 2;
      sy = s < cs;
      tk = dv == cd;
      fs = p == 0;
      for (int k = 0; k < NC; k++)
        dat[k] = cm == 0 ? (s < (cf + 1) / 2) : cm == 1 ? (s % NC == k) : cm == 2 ? prbs_bit(k, s) : 1'b0;
    end else s = 0;
    nst = mst == 0 ? (en ? 1 : 0) : (!en && bnd) ? 0 : en ? 1 : 2;
    if (pflag && (mst == 0 || bnd)) begin
      cd = pd < 1 ? 1 : pd; cf = pf == 0 ? 1 : pf; cs = ps; cm = pm; pflag = 0;
    end
    if (cfg_load) begin
      pd = int'(cfg_div); pf = int'(cfg_frame); ps = int'(cfg_sync); pm = int'(cfg_mode); pflag = 1;
    end
    p = (mst == 0 || bnd) ? 0 : p + 1;
    mst = nst;
    exp_q.push_back({nst != 0, sp, sy, dat, tk, fs, FN'(s)});
  endtask

  initial forever begin
    @(posedge mclk or negedge reset_n);
    model_step();
  end

  initial forever begin
    logic [OW-1:0] e;
    @(negedge mclk);
    e = exp_q.size() != 0 ? exp_q.pop_front() : '0;
    n_chk++;
    if (outs() !== e) begin
      n_fail++;
      if (n_fail <= 20) $display("FAIL outputs t=%0t got %h expected %h", $time, outs(), e);
    end
  end

  task automatic tick(int n);
    repeat (n) begin @(posedge mclk); #2; end
  endtask

  task automatic load(int d, int f, int s, int m);
    cfg_div = DN'(d); cfg_frame = FN'(f); cfg_sync = FN'(s); cfg_mode = 2'(m);
    cfg_load = 1'b1;
    tick(1);
    cfg_load = 1'b0;
  endtask

  initial begin
    tick(3);
    reset_n = 1'b1; en = 1'b1;
    tick(6000);
    reset_n = 1'b0;
    #1;
    n_chk++;
    if (outs() !== '0) begin
      n_fail++;
      $display("FAIL async_reset got %h expected 0", outs());
    end
    tick(2);
    en = 1'b0; reset_n = 1'b1;
    tick(2);
    load(4, 7, 2, 0); en = 1'b1; tick(100);
    load(2, 3, 1, 1); tick(150);
    load(0, 0, 1, 1); tick(30);
    load(2, 7, 0, 0); tick(120);
    load(2, 7, 20, 0); tick(120);
    load(3, 7, 3, 0); en = 1'b0; tick(200);
    en = 1'b1; tick(14); en = 1'b0; tick(40);
    en = 1'b1; tick(10); en = 1'b0; tick(6); en = 1'b1; tick(60);
    load(2, 5, 2, 2); tick(200);
    load(1, 9, 4, 2); tick(200);
    load(0, 3, 1, 2); tick(100);
    en = 1'b1; tick(3); reset_n = 1'b0; tick(1); reset_n = 1'b1; tick(20);
    for (int i = 0; i < 60; i++) begin
      if ($urandom % 3 == 0)
        load($urandom_range(0, 6), $urandom_range(0, 12), $urandom_range(0, 14), $urandom_range(0, 3));
      en = ($urandom % 4) != 0;
      tick($urandom_range(5, 120));
    end
    en = 1'b0; tick(400);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
